// File: rtl/cart_sdram_arbiter_if.sv
// Purpose: SDRAM controller request/acknowledge bus shared by the cartridge arbiter.
// Ports:   mem_req/mem_we/mem_addr/mem_din go from the arbiter (master) to the controller;
//          mem_ack (one-cycle completion pulse) and mem_dout (read data in the ack cycle)
//          come back from the controller (slave).
interface cart_sdram_arbiter_if #(
   parameter int unsigned AW = 25
);
   localparam int unsigned DW = 8;

   logic          mem_req;
   logic          mem_we;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_din;
   logic          mem_ack;
   logic [DW-1:0] mem_dout;

   modport master (
      output mem_req,
      output mem_we,
      output mem_addr,
      output mem_din,
      input  mem_ack,
      input  mem_dout
   );

   modport slave (
      input  mem_req,
      input  mem_we,
      input  mem_addr,
      input  mem_din,
      output mem_ack,
      output mem_dout
   );
endinterface

// File: rtl/cart_sdram_arbiter.sv
// Purpose: shares one SDRAM controller port between Z80 cartridge reads and ioctl
//          ROM-download writes. Round-robin arbitration, one-entry write buffer,
//          one-entry read cache. All outputs registered.
// Ports:   clk, reset_n (async active-low)
//          cpu_req/cpu_addr in, cpu_q/cpu_wait_n out      : Z80 read side
//          ioctl_wr/ioctl_addr/ioctl_dout in,
//          ioctl_wait/ovf_err out                         : download write side
//          mem (cart_sdram_arbiter_if.master)             : SDRAM controller bus
module cart_sdram_arbiter #(
   parameter int unsigned AW = 25
) (
   input  logic                 clk,
   input  logic                 reset_n,

   input  logic                 cpu_req,
   input  logic [AW-1:0]        cpu_addr,
   output logic [7:0]           cpu_q,
   output logic                 cpu_wait_n,

   input  logic                 ioctl_wr,
   input  logic [AW-1:0]        ioctl_addr,
   input  logic [7:0]           ioctl_dout,
   output logic                 ioctl_wait,
   output logic                 ovf_err,

   cart_sdram_arbiter_if.master mem
);

   localparam int unsigned DW = 8;
   localparam logic GRANT_IO  = 1'b0;
   localparam logic GRANT_CPU = 1'b1;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_CPU_RD = 2'd1,
      ST_IO_WR  = 2'd2
   } state_e;

   state_e        state_q, state_d;
   logic          last_grant_q, last_grant_d;
   logic          served_q, served_d;
   logic          buf_full_q, buf_full_d;
   logic [AW-1:0] buf_addr_q, buf_addr_d;
   logic [DW-1:0] buf_data_q, buf_data_d;
   logic          cache_valid_q, cache_valid_d;
   logic [AW-1:0] cache_tag_q, cache_tag_d;
   logic [DW-1:0] cache_data_q, cache_data_d;
   logic [DW-1:0] cpu_q_q, cpu_q_d;
   logic          cpu_wait_n_q, cpu_wait_n_d;
   logic          ovf_err_q, ovf_err_d;
   logic          mem_req_q, mem_req_d;
   logic          mem_we_q, mem_we_d;
   logic [AW-1:0] mem_addr_q, mem_addr_d;
   logic [DW-1:0] mem_din_q, mem_din_d;

   logic cpu_pending;
   logic cache_hit;
   logic cpu_miss;
   logic wr_pending;

   // Request qualifiers used by the IDLE arbiter
   always_comb begin
      cpu_pending = cpu_req & ~served_q;
      cache_hit   = cache_valid_q & (cache_tag_q == cpu_addr);
      cpu_miss    = cpu_pending & ~cache_hit;
      wr_pending  = buf_full_q;
   end

   // Next-state and registered-output logic
   always_comb begin
      state_d       = state_q;
      last_grant_d  = last_grant_q;
      served_d      = cpu_req ? served_q : 1'b0;
      buf_full_d    = buf_full_q;
      buf_addr_d    = buf_addr_q;
      buf_data_d    = buf_data_q;
      cache_valid_d = cache_valid_q;
      cache_tag_d   = cache_tag_q;
      cache_data_d  = cache_data_q;
      cpu_q_d       = cpu_q_q;
      cpu_wait_n_d  = cpu_wait_n_q;
      ovf_err_d     = ovf_err_q;
      mem_req_d     = mem_req_q;
      mem_we_d      = mem_we_q;
      mem_addr_d    = mem_addr_q;
      mem_din_d     = mem_din_q;

      // Write buffer capture; a strobe landing on the freeing ack edge still sees full_q and is dropped
      if (ioctl_wr) begin
         if (buf_full_q) begin
            ovf_err_d = 1'b1;
         end else begin
            buf_full_d = 1'b1;
            buf_addr_d = ioctl_addr;
            buf_data_d = ioctl_dout;
         end
      end

      case (state_q)
         ST_IDLE: begin
            if (cpu_pending && cache_hit) begin
               cpu_q_d  = cache_data_q;
               served_d = 1'b1;
            end
            if (cpu_miss && (!wr_pending || last_grant_q == GRANT_IO)) begin
               state_d      = ST_CPU_RD;
               mem_req_d    = 1'b1;
               mem_we_d     = 1'b0;
               mem_addr_d   = cpu_addr;
               cpu_wait_n_d = 1'b0;
            end else if (wr_pending && (!cpu_miss || last_grant_q == GRANT_CPU)) begin
               state_d       = ST_IO_WR;
               mem_req_d     = 1'b1;
               mem_we_d      = 1'b1;
               mem_addr_d    = buf_addr_q;
               mem_din_d     = buf_data_q;
               // Invalidate at grant so no later hit can return pre-write data
               cache_valid_d = 1'b0;
            end
         end

         ST_CPU_RD: begin
            if (mem.mem_ack) begin
               state_d       = ST_IDLE;
               cpu_q_d       = mem.mem_dout;
               // Tag from the captured address: cpu_addr may have moved if cpu_req fell
               cache_tag_d   = mem_addr_q;
               cache_data_d  = mem.mem_dout;
               cache_valid_d = 1'b1;
               served_d      = cpu_req;
               cpu_wait_n_d  = 1'b1;
               mem_req_d     = 1'b0;
               last_grant_d  = GRANT_CPU;
            end
         end

         ST_IO_WR: begin
            if (mem.mem_ack) begin
               state_d      = ST_IDLE;
               buf_full_d   = 1'b0;
               mem_req_d    = 1'b0;
               last_grant_d = GRANT_IO;
            end
         end

         default: begin
            state_d   = ST_IDLE;
            mem_req_d = 1'b0;
         end
      endcase
   end

   // State and output registers
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q       <= ST_IDLE;
         last_grant_q  <= GRANT_IO;
         served_q      <= 1'b0;
         buf_full_q    <= 1'b0;
         buf_addr_q    <= '0;
         buf_data_q    <= '0;
         cache_valid_q <= 1'b0;
         cache_tag_q   <= '0;
         cache_data_q  <= '0;
         cpu_q_q       <= 8'hFF;
         cpu_wait_n_q  <= 1'b1;
         ovf_err_q     <= 1'b0;
         mem_req_q     <= 1'b0;
         mem_we_q      <= 1'b0;
         mem_addr_q    <= '0;
         mem_din_q     <= '0;
      end else begin
         state_q       <= state_d;
         last_grant_q  <= last_grant_d;
         served_q      <= served_d;
         buf_full_q    <= buf_full_d;
         buf_addr_q    <= buf_addr_d;
         buf_data_q    <= buf_data_d;
         cache_valid_q <= cache_valid_d;
         cache_tag_q   <= cache_tag_d;
         cache_data_q  <= cache_data_d;
         cpu_q_q       <= cpu_q_d;
         cpu_wait_n_q  <= cpu_wait_n_d;
         ovf_err_q     <= ovf_err_d;
         mem_req_q     <= mem_req_d;
         mem_we_q      <= mem_we_d;
         mem_addr_q    <= mem_addr_d;
         mem_din_q     <= mem_din_d;
      end
   end

   assign cpu_q        = cpu_q_q;
   assign cpu_wait_n   = cpu_wait_n_q;
   assign ioctl_wait   = buf_full_q;
   assign ovf_err      = ovf_err_q;
   assign mem.mem_req  = mem_req_q;
   assign mem.mem_we   = mem_we_q;
   assign mem.mem_addr = mem_addr_q;
   assign mem.mem_din  = mem_din_q;

endmodule

// File: tb/tb_cart_sdram_arbiter.sv
// Purpose: directed self-checking bench for cart_sdram_arbiter. Inputs are driven and
//          outputs sampled on the falling edge; the SDRAM controller is emulated inline.
module tb_cart_sdram_arbiter;

   localparam int unsigned AW = 25;

   logic          clk;
   logic          reset_n;
   logic          cpu_req;
   logic [AW-1:0] cpu_addr;
   logic [7:0]    cpu_q;
   logic          cpu_wait_n;
   logic          ioctl_wr;
   logic [AW-1:0] ioctl_addr;
   logic [7:0]    ioctl_dout;
   logic          ioctl_wait;
   logic          ovf_err;

   int checks = 0;
   int errors = 0;

   cart_sdram_arbiter_if #(.AW(AW)) mif ();

   cart_sdram_arbiter #(.AW(AW)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .cpu_req    (cpu_req),
      .cpu_addr   (cpu_addr),
      .cpu_q      (cpu_q),
      .cpu_wait_n (cpu_wait_n),
      .ioctl_wr   (ioctl_wr),
      .ioctl_addr (ioctl_addr),
      .ioctl_dout (ioctl_dout),
      .ioctl_wait (ioctl_wait),
      .ovf_err    (ovf_err),
      .mem        (mif)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(negedge clk);
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   initial begin
      reset_n      = 1'b0;
      cpu_req      = 1'b0;
      cpu_addr     = '0;
      ioctl_wr     = 1'b0;
      ioctl_addr   = '0;
      ioctl_dout   = '0;
      mif.mem_ack  = 1'b0;
      mif.mem_dout = '0;

      // Reset values
      step(); step();
      chk("rst mem_req",    32'(mif.mem_req),  32'd0);
      chk("rst mem_we",     32'(mif.mem_we),   32'd0);
      chk("rst mem_addr",   32'(mif.mem_addr), 32'd0);
      chk("rst mem_din",    32'(mif.mem_din),  32'd0);
      chk("rst cpu_q",      32'(cpu_q),        32'hFF);
      chk("rst cpu_wait_n", 32'(cpu_wait_n),   32'd1);
      chk("rst ioctl_wait", 32'(ioctl_wait),   32'd0);
      chk("rst ovf_err",    32'(ovf_err),      32'd0);
      reset_n = 1'b1;
      step();

      // Cold miss at 0x0004000, ack after a 5 clk wait window
      cpu_req  = 1'b1;
      cpu_addr = 25'h0004000;
      step();
      chk("miss mem_req",   32'(mif.mem_req),  32'd1);
      chk("miss mem_we",    32'(mif.mem_we),   32'd0);
      chk("miss mem_addr",  32'(mif.mem_addr), 32'h0004000);
      chk("miss wait0",     32'(cpu_wait_n),   32'd0);
      for (int i = 1; i <= 4; i++) begin
         step();
         chk("miss wait held", 32'(cpu_wait_n),  32'd0);
         chk("miss req held",  32'(mif.mem_req), 32'd1);
      end
      mif.mem_ack  = 1'b1;
      mif.mem_dout = 8'h3C;
      step();
      mif.mem_ack = 1'b0;
      chk("miss wait rel",  32'(cpu_wait_n),  32'd1);
      chk("miss cpu_q",     32'(cpu_q),       32'h3C);
      chk("miss req drop",  32'(mif.mem_req), 32'd0);
      cpu_req = 1'b0;
      step();

      // Hit on the same address: no SDRAM access, no wait
      cpu_req  = 1'b1;
      cpu_addr = 25'h0004000;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("hit mem_req",  32'(mif.mem_req), 32'd0);
         chk("hit wait_n",   32'(cpu_wait_n),  32'd1);
         chk("hit cpu_q",    32'(cpu_q),       32'h3C);
      end
      cpu_req = 1'b0;
      step();

      // Download write to the cached address invalidates the cache
      ioctl_wr   = 1'b1;
      ioctl_addr = 25'h0004000;
      ioctl_dout = 8'h55;
      step();
      ioctl_wr = 1'b0;
      chk("wr ioctl_wait",  32'(ioctl_wait),   32'd1);
      chk("wr req latency", 32'(mif.mem_req),  32'd0);
      step();
      chk("wr mem_req",     32'(mif.mem_req),  32'd1);
      chk("wr mem_we",      32'(mif.mem_we),   32'd1);
      chk("wr mem_addr",    32'(mif.mem_addr), 32'h0004000);
      chk("wr mem_din",     32'(mif.mem_din),  32'h55);
      step();
      chk("wr wait held",   32'(ioctl_wait),   32'd1);
      mif.mem_ack = 1'b1;
      step();
      mif.mem_ack = 1'b0;
      chk("wr req drop",    32'(mif.mem_req),  32'd0);
      chk("wr wait drop",   32'(ioctl_wait),   32'd0);
      cpu_req  = 1'b1;
      cpu_addr = 25'h0004000;
      step();
      chk("inv miss req",   32'(mif.mem_req),  32'd1);
      chk("inv miss we",    32'(mif.mem_we),   32'd0);
      chk("inv miss wait",  32'(cpu_wait_n),   32'd0);
      mif.mem_ack  = 1'b1;
      mif.mem_dout = 8'h55;
      step();
      mif.mem_ack = 1'b0;
      chk("inv miss q",     32'(cpu_q),        32'h55);
      cpu_req = 1'b0;
      step();

      // Standalone write so the round-robin bit points at IO
      ioctl_wr   = 1'b1;
      ioctl_addr = 25'h0000100;
      ioctl_dout = 8'h11;
      step();
      ioctl_wr = 1'b0;
      step();
      chk("rr pre we",      32'(mif.mem_we),   32'd1);
      mif.mem_ack = 1'b1;
      step();
      mif.mem_ack = 1'b0;

      // Conflicts: expected grant order CPU, IO, CPU, IO
      ioctl_wr   = 1'b1;
      ioctl_addr = 25'h0000200;
      ioctl_dout = 8'hAA;
      step();
      ioctl_wr = 1'b0;
      cpu_req  = 1'b1;
      cpu_addr = 25'h0000300;
      chk("rr buf full",    32'(ioctl_wait),   32'd1);
      step();
      chk("rr g1 req",      32'(mif.mem_req),  32'd1);
      chk("rr g1 we",       32'(mif.mem_we),   32'd0);
      chk("rr g1 addr",     32'(mif.mem_addr), 32'h0000300);
      mif.mem_ack  = 1'b1;
      mif.mem_dout = 8'h77;
      cpu_req      = 1'b0;
      step();
      mif.mem_ack = 1'b0;
      chk("rr g1 q",        32'(cpu_q),        32'h77);
      chk("rr g1 drop",     32'(mif.mem_req),  32'd0);
      cpu_req  = 1'b1;
      cpu_addr = 25'h0000301;
      step();
      chk("rr g2 we",       32'(mif.mem_we),   32'd1);
      chk("rr g2 addr",     32'(mif.mem_addr), 32'h0000200);
      chk("rr g2 din",      32'(mif.mem_din),  32'hAA);
      chk("rr g2 cpu wait", 32'(cpu_wait_n),   32'd1);
      mif.mem_ack = 1'b1;
      step();
      mif.mem_ack = 1'b0;
      chk("rr g2 drop",     32'(mif.mem_req),  32'd0);
      ioctl_wr   = 1'b1;
      ioctl_addr = 25'h0000201;
      ioctl_dout = 8'hBB;
      step();
      ioctl_wr = 1'b0;
      chk("rr g3 we",       32'(mif.mem_we),   32'd0);
      chk("rr g3 addr",     32'(mif.mem_addr), 32'h0000301);
      chk("rr g3 wait",     32'(ioctl_wait),   32'd1);
      mif.mem_ack  = 1'b1;
      mif.mem_dout = 8'h78;
      cpu_req      = 1'b0;
      step();
      mif.mem_ack = 1'b0;
      chk("rr g3 q",        32'(cpu_q),        32'h78);
      step();
      chk("rr g4 we",       32'(mif.mem_we),   32'd1);
      chk("rr g4 addr",     32'(mif.mem_addr), 32'h0000201);
      chk("rr g4 din",      32'(mif.mem_din),  32'hBB);
      mif.mem_ack = 1'b1;
      step();
      mif.mem_ack = 1'b0;
      chk("rr g4 drop",     32'(mif.mem_req),  32'd0);
      chk("rr g4 wait",     32'(ioctl_wait),   32'd0);

      // Overflow with the controller stalled
      ioctl_wr   = 1'b1;
      ioctl_addr = 25'h0000400;
      ioctl_dout = 8'h12;
      step();
      ioctl_wr = 1'b0;
      chk("ovf first ok",   32'(ovf_err),      32'd0);
      step();
      chk("ovf wr req",     32'(mif.mem_req),  32'd1);
      ioctl_wr   = 1'b1;
      ioctl_addr = 25'h0000401;
      ioctl_dout = 8'h34;
      step();
      ioctl_wr = 1'b0;
      chk("ovf set",        32'(ovf_err),      32'd1);
      for (int i = 0; i < 3; i++) begin
         chk("ovf addr stable", 32'(mif.mem_addr), 32'h0000400);
         chk("ovf din stable",  32'(mif.mem_din),  32'h12);
         step();
      end
      mif.mem_ack = 1'b1;
      step();
      mif.mem_ack = 1'b0;
      chk("ovf wait drop",  32'(ioctl_wait),   32'd0);
      for (int i = 0; i < 3; i++) begin
         chk("ovf single wr", 32'(mif.mem_req), 32'd0);
         step();
      end
      chk("ovf sticky",     32'(ovf_err),      32'd1);

      // Fill cache with 0x500, then reset during a miss on 0x600
      cpu_req  = 1'b1;
      cpu_addr = 25'h0000500;
      step();
      mif.mem_ack  = 1'b1;
      mif.mem_dout = 8'h9A;
      step();
      mif.mem_ack = 1'b0;
      chk("pre rst q",      32'(cpu_q),        32'h9A);
      cpu_req = 1'b0;
      step();
      cpu_req  = 1'b1;
      cpu_addr = 25'h0000600;
      step();
      chk("mid rd req",     32'(mif.mem_req),  32'd1);
      reset_n = 1'b0;
      #1;
      chk("arst mem_req",   32'(mif.mem_req),  32'd0);
      chk("arst wait_n",    32'(cpu_wait_n),   32'd1);
      chk("arst ovf",       32'(ovf_err),      32'd0);
      chk("arst cpu_q",     32'(cpu_q),        32'hFF);
      cpu_req = 1'b0;
      step();
      step();
      reset_n = 1'b1;
      step();
      cpu_req  = 1'b1;
      cpu_addr = 25'h0000500;
      step();
      chk("post rst miss",  32'(mif.mem_req),  32'd1);
      chk("post rst addr",  32'(mif.mem_addr), 32'h0000500);
      chk("post rst wait",  32'(cpu_wait_n),   32'd0);
      mif.mem_ack  = 1'b1;
      mif.mem_dout = 8'h9A;
      step();
      mif.mem_ack = 1'b0;
      cpu_req     = 1'b0;
      chk("post rst q",     32'(cpu_q),        32'h9A);
      chk("post rst rel",   32'(cpu_wait_n),   32'd1);
      step();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
